// File: rtl/divider_pkg.sv
// Shared types and defaults for the parametrised divider.
package divider_pkg;

  localparam int DIV_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration of the divider.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dvnd_bit,
  input  logic [WIDTH-1:0] dvsr,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  // Shift in the next dividend bit, subtract the divisor when it fits.
  // A kept remainder is always below the divisor, so the low WIDTH bits
  // of the difference are exact whenever the subtraction is taken.
  always_comb begin
    shifted = {rem_in, dvnd_bit};
    diff    = shifted[WIDTH-1:0] - dvsr;
    q_bit   = (shifted >= {1'b0, dvsr});
    rem_out = q_bit ? diff : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/param_divider.sv
// Sequential signed/unsigned integer divider behind a Run/Rdy level handshake.
module param_divider
  import divider_pkg::*;
#(
  parameter  int WIDTH = DIV_WIDTH_DEFAULT,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             Rst,
  input  logic             Run,
  input  logic             Signed,
  input  logic [WIDTH-1:0] Dvnd,
  input  logic [WIDTH-1:0] Dvsr,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             Rdy,
  output logic             DivZero,
  output logic             Busy
);

  state_t           state;
  state_t           state_nxt;
  // Dividend magnitude shifts out MSB-first while quotient bits shift in at the LSB.
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvsr_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] rem_nxt;
  logic             q_bit;
  logic             neg_q;
  logic             neg_r;
  logic [CNT_W-1:0] cnt;
  logic             dvsr_zero;
  logic             last_iter;
  logic [WIDTH-1:0] dvnd_mag;
  logic [WIDTH-1:0] dvsr_mag;

  assign dvsr_zero = (Dvsr == '0);
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));
  assign Rdy       = (state == DONE);
  assign Busy      = (state == CALC) || (state == FIX);

  // Operand magnitudes; the most negative value wraps to itself, which
  // the unsigned iteration then treats as 2**(WIDTH-1).
  always_comb begin
    dvnd_mag = (Signed && Dvnd[WIDTH-1]) ? -Dvnd : Dvnd;
    dvsr_mag = (Signed && Dvsr[WIDTH-1]) ? -Dvsr : Dvsr;
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in   (rem_q),
    .dvnd_bit (quo_q[WIDTH-1]),
    .dvsr     (dvsr_q),
    .rem_out  (rem_nxt),
    .q_bit    (q_bit)
  );

  // State register.
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Run) state_nxt = dvsr_zero ? DONE : CALC;
      CALC:    if (last_iter) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    if (!Run) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      quo_q   <= '0;
      dvsr_q  <= '0;
      rem_q   <= '0;
      cnt     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      Q       <= '0;
      R       <= '0;
      DivZero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Run) begin
            if (dvsr_zero) begin
              Q       <= '1;
              R       <= Dvnd;
              DivZero <= 1'b1;
            end else begin
              quo_q   <= dvnd_mag;
              dvsr_q  <= dvsr_mag;
              rem_q   <= '0;
              cnt     <= '0;
              neg_q   <= Signed & (Dvnd[WIDTH-1] ^ Dvsr[WIDTH-1]);
              neg_r   <= Signed & Dvnd[WIDTH-1];
              DivZero <= 1'b0;
            end
          end
        end
        CALC: begin
          quo_q <= {quo_q[WIDTH-2:0], q_bit};
          rem_q <= rem_nxt;
          cnt   <= cnt + CNT_W'(1);
        end
        FIX: begin
          Q <= neg_q ? -quo_q : quo_q;
          R <= neg_r ? -rem_q : rem_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_param_divider.sv
// Directed self-checking bench for param_divider at WIDTH=32 and WIDTH=8.
module tb_param_divider;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        rst32 = 1'b1, run32 = 1'b0, sgn32 = 1'b0;
  logic [31:0] dvnd32 = '0, dvsr32 = '0, q32, r32;
  logic        rdy32, dz32, busy32;

  logic        rst8 = 1'b1, run8 = 1'b0, sgn8 = 1'b0;
  logic [7:0]  dvnd8 = '0, dvsr8 = '0, q8, r8;
  logic        rdy8, dz8, busy8;

  param_divider #(.WIDTH(32)) dut32 (
    .clk(clk), .Rst(rst32), .Run(run32), .Signed(sgn32), .Dvnd(dvnd32), .Dvsr(dvsr32),
    .Q(q32), .R(r32), .Rdy(rdy32), .DivZero(dz32), .Busy(busy32)
  );

  param_divider #(.WIDTH(8)) dut8 (
    .clk(clk), .Rst(rst8), .Run(run8), .Signed(sgn8), .Dvnd(dvnd8), .Dvsr(dvsr8),
    .Q(q8), .R(r8), .Rdy(rdy8), .DivZero(dz8), .Busy(busy8)
  );

  // Start a 32-bit operation and wait (bounded) for Rdy; operands are
  // scrambled right after the start edge.
  task automatic op32(input logic s, input logic [31:0] a, input logic [31:0] b,
                      output int edges, output logic busy1);
    @(negedge clk);
    sgn32 = s; dvnd32 = a; dvsr32 = b; run32 = 1'b1;
    edges = 0; busy1 = 1'b0;
    do begin
      @(posedge clk); #1; edges++;
      if (edges == 1) begin
        busy1 = busy32; sgn32 = ~s; dvnd32 = ~a; dvsr32 = b + 32'd3;
      end
    end while (!rdy32 && edges < 100);
  endtask

  task automatic release32;
    @(negedge clk); run32 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (rdy32 !== 1'b0) begin errors++; $display("FAIL rdy32_fall: got %b expected 0", rdy32); end
  endtask

  task automatic op8(input logic s, input logic [7:0] a, input logic [7:0] b,
                     input int drop_after, output int edges);
    @(negedge clk);
    sgn8 = s; dvnd8 = a; dvsr8 = b; run8 = 1'b1;
    edges = 0;
    do begin
      @(posedge clk); #1; edges++;
      if (edges == 1) begin sgn8 = ~s; dvnd8 = ~a; dvsr8 = b + 8'd5; end
      if (drop_after != 0 && edges == drop_after) run8 = 1'b0;
    end while (!rdy8 && edges < 100);
  endtask

  task automatic release8;
    @(negedge clk); run8 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (rdy8 !== 1'b0) begin errors++; $display("FAIL rdy8_fall: got %b expected 0", rdy8); end
  endtask

  task automatic test_reset;
    rst32 = 1'b1; rst8 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({q32, r32, rdy32, dz32, busy32} !== 67'd0) begin
      errors++; $display("FAIL reset32: got q=%h r=%h rdy=%b dz=%b busy=%b expected all 0", q32, r32, rdy32, dz32, busy32);
    end
    checks++;
    if ({q8, r8, rdy8, dz8, busy8} !== 19'd0) begin
      errors++; $display("FAIL reset8: got q=%h r=%h rdy=%b dz=%b busy=%b expected all 0", q8, r8, rdy8, dz8, busy8);
    end
    @(negedge clk); rst32 = 1'b0; rst8 = 1'b0;
  endtask

  task automatic test_unsigned;
    int e; logic b1;
    op32(1'b0, 32'h0000_0064, 32'h0000_0007, e, b1);
    checks++; if (e !== 34) begin errors++; $display("FAIL u_latency: got %0d expected 34", e); end
    checks++; if (q32 !== 32'h0000_000E) begin errors++; $display("FAIL u_q: got %h expected 0000000e", q32); end
    checks++; if (r32 !== 32'h0000_0002) begin errors++; $display("FAIL u_r: got %h expected 00000002", r32); end
    checks++; if (dz32 !== 1'b0) begin errors++; $display("FAIL u_dz: got %b expected 0", dz32); end
    checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL u_busy: got %b expected 1", b1); end
    checks++; if (busy32 !== 1'b0) begin errors++; $display("FAIL u_busy_done: got %b expected 0", busy32); end
    release32;
  endtask

  task automatic test_signed;
    int e; logic b1;
    op32(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, e, b1);
    checks++; if (q32 !== 32'hFFFF_FFFD) begin errors++; $display("FAIL s_q: got %h expected fffffffd", q32); end
    checks++; if (r32 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL s_r: got %h expected ffffffff", r32); end
    release32;
    op32(1'b0, 32'hFFFF_FFF9, 32'h0000_0002, e, b1);
    checks++; if (q32 !== 32'h7FFF_FFFC) begin errors++; $display("FAIL su_q: got %h expected 7ffffffc", q32); end
    checks++; if (r32 !== 32'h0000_0001) begin errors++; $display("FAIL su_r: got %h expected 00000001", r32); end
    release32;
  endtask

  task automatic test_divzero;
    int e; logic b1;
    for (int m = 0; m < 2; m++) begin
      op32(m[0], 32'h1234_5678, 32'h0000_0000, e, b1);
      checks++; if (e !== 1) begin errors++; $display("FAIL dz_latency mode=%0d: got %0d expected 1", m, e); end
      checks++; if (q32 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz_q mode=%0d: got %h expected ffffffff", m, q32); end
      checks++; if (r32 !== 32'h1234_5678) begin errors++; $display("FAIL dz_r mode=%0d: got %h expected 12345678", m, r32); end
      checks++; if (dz32 !== 1'b1) begin errors++; $display("FAIL dz_flag mode=%0d: got %b expected 1", m, dz32); end
      release32;
    end
  endtask

  task automatic test_overflow;
    int e; logic b1;
    op32(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, e, b1);
    checks++; if (q32 !== 32'h8000_0000) begin errors++; $display("FAIL ovf_q: got %h expected 80000000", q32); end
    checks++; if (r32 !== 32'h0000_0000) begin errors++; $display("FAIL ovf_r: got %h expected 00000000", r32); end
    checks++; if (dz32 !== 1'b0) begin errors++; $display("FAIL ovf_dz: got %b expected 0", dz32); end
    release32;
  endtask

  task automatic test_reset_mid_calc;
    int e;
    op8(1'b0, 8'hC8, 8'h07, 0, e);
    checks++; if ({q8, r8} !== {8'h1C, 8'h04}) begin errors++; $display("FAIL pre_rst: got q=%h r=%h expected 1c 04", q8, r8); end
    release8;
    @(negedge clk); sgn8 = 1'b0; dvnd8 = 8'hFF; dvsr8 = 8'h03; run8 = 1'b1;
    repeat (4) @(posedge clk);
    #2 rst8 = 1'b1;
    #1;
    checks++;
    if ({q8, r8, rdy8, dz8, busy8} !== 19'd0) begin
      errors++; $display("FAIL rst_async: got q=%h r=%h rdy=%b dz=%b busy=%b expected all 0", q8, r8, rdy8, dz8, busy8);
    end
    @(negedge clk); run8 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({q8, r8, rdy8, dz8, busy8} !== 19'd0) begin
      errors++; $display("FAIL rst_hold: got q=%h r=%h rdy=%b dz=%b busy=%b expected all 0", q8, r8, rdy8, dz8, busy8);
    end
    @(negedge clk); rst8 = 1'b0;
    op8(1'b0, 8'hFF, 8'h10, 0, e);
    checks++; if (e !== 10) begin errors++; $display("FAIL post_rst_latency: got %0d expected 10", e); end
    checks++; if ({q8, r8} !== {8'h0F, 8'h0F}) begin errors++; $display("FAIL post_rst: got q=%h r=%h expected 0f 0f", q8, r8); end
    release8;
  endtask

  task automatic test_handshake;
    int  e;
    logic held_ok;
    op8(1'b0, 8'h64, 8'h0A, 3, e);
    checks++; if (e !== 10) begin errors++; $display("FAIL drop_latency: got %0d expected 10", e); end
    checks++; if ({q8, r8} !== {8'h0A, 8'h00}) begin errors++; $display("FAIL drop_result: got q=%h r=%h expected 0a 00", q8, r8); end
    @(posedge clk); #1;
    checks++; if (rdy8 !== 1'b0) begin errors++; $display("FAIL drop_one_cycle: got %b expected 0", rdy8); end

    op8(1'b0, 8'h3A, 8'h05, 0, e);
    checks++; if ({q8, r8} !== {8'h0B, 8'h03}) begin errors++; $display("FAIL held_result: got q=%h r=%h expected 0b 03", q8, r8); end
    held_ok = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (rdy8 !== 1'b1 || q8 !== 8'h0B) held_ok = 1'b0;
    end
    checks++; if (held_ok !== 1'b1) begin errors++; $display("FAIL held_rdy: got %b expected 1", held_ok); end
    release8;

    op8(1'b1, 8'h81, 8'h02, 0, e);
    checks++; if (e !== 10) begin errors++; $display("FAIL b2b_latency: got %0d expected 10", e); end
    checks++; if ({q8, r8} !== {8'hC1, 8'hFF}) begin errors++; $display("FAIL b2b_result: got q=%h r=%h expected c1 ff", q8, r8); end
    release8;
  endtask

  initial begin
    test_reset;
    test_unsigned;
    test_signed;
    test_divzero;
    test_overflow;
    test_reset_mid_calc;
    test_handshake;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_divider.md
# param_divider

Parametrised sequential integer divider, successor to the fixed 32-bit unsigned complete divider. It computes quotient and remainder for a configurable operand width. A per-operation Signed input selects unsigned or two's-complement mode, and the block flags divide-by-zero. It sits behind the same Run/Rdy level handshake as the existing divider, so existing benches and control logic drive it unchanged.

## Interface
- WIDTH, 32, operand/result width in bits (≥ 2)
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden)
- clk  input  1  rising-edge clock
- Rst  input  1  reset, asynchronous, active-high
- Run  input  1  start request; level, held high until Rdy seen
- Signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with operands
- Dvnd  input  WIDTH  dividend; sampled at start
- Dvsr  input  WIDTH  divisor; sampled at start
- Q  output  WIDTH  quotient
- R  output  WIDTH  remainder
- Rdy  output  1  result valid
- DivZero  output  1  last operation had Dvsr == 0; valid while Rdy
- Busy  output  1  high in CALC and FIX

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE: if Run=1 at an edge:
  - latch Signed and operands; divisor zero → DONE directly.
  - otherwise latch magnitudes (abs value when Signed, raw when unsigned), record negQ = Signed & (Dvnd[MSB]^Dvsr[MSB]) and negR = Signed & Dvnd[MSB], clear partial remainder, counter=0 → CALC.
- CALC: restoring shift-subtract, one quotient bit per cycle, MSB first.
  - Partial remainder is WIDTH+1 bits to hold the shifted-in value before compare.
  - After WIDTH iterations → FIX.
- FIX: Q = negQ ? -q : q; R = negR ? -r : r (WIDTH-bit wrap) → DONE.
- DONE: Rdy=1; Q/R/DivZero held. Stays while Run=1; Run=0 at an edge → IDLE.
- Divide by zero: Q = all ones, R = Dvnd (unsigned and signed), DivZero=1.
- Signed overflow (most negative value / −1): Q = most negative value, R = 0, DivZero=0. This falls out naturally from the magnitude path; no special case.
- Results truncate toward zero; remainder carries the dividend's sign.
- Q, R, DivZero keep their last values in IDLE and change only on FIX/DONE entry. DivZero clears on any new start.

## Timing
- Reset (async, any state): state=IDLE; Q=0, R=0, Rdy=0, DivZero=0, Busy=0. Reset mid-CALC aborts with no residual state.
- Start edge = first edge with IDLE & Run=1.
- Normal latency: CALC occupies WIDTH edges, FIX one edge. Rdy rises after start edge + WIDTH + 1 further edges (34 edges total for WIDTH=32).
- Divide-by-zero latency: Rdy rises at the edge after the start edge (1 edge).
- Run dropped during CALC/FIX: ignored; the operation completes. On reaching DONE with Run=0, Rdy is high exactly one cycle, then IDLE.
- Rdy falls on the edge that samples Run=0 in DONE. A new start needs IDLE & Run=1 at a later edge; minimum one IDLE cycle between operations.
- Operand or Signed changes after the start edge do not affect the result.

## Structure
- Package divider_pkg: state enum (IDLE, CALC, FIX, DONE), DIV_WIDTH_DEFAULT = 32.
- Sub-module div_step: combinational single iteration {rem_in, dividend bit, divisor} → {rem_out, q_bit}; instantiated once in param_divider.
- Top: FSM, operand/sign registers, counter, FIX negation.

## Test plan
- WIDTH=32, unsigned, Dvnd=0x0000_0064, Dvsr=0x0000_0007 → Q=0x0E, R=0x02, DivZero=0, Rdy exactly 34 edges after start.
- WIDTH=32, signed, Dvnd=−7 (0xFFFF_FFF9), Dvsr=2 → Q=0xFFFF_FFFD (−3), R=0xFFFF_FFFF (−1). Unsigned mode, same operands → Q=0x7FFF_FFFC, R=1.
- WIDTH=32, Dvsr=0, Dvnd=0x1234_5678, both modes → Q=0xFFFF_FFFF, R=0x1234_5678, DivZero=1, Rdy at the edge after start.
- WIDTH=32, signed, Dvnd=0x8000_0000, Dvsr=0xFFFF_FFFF → Q=0x8000_0000, R=0, DivZero=0.
- WIDTH=8, Rst asserted mid-CALC, then unsigned 0xFF/0x10 → all outputs 0 during reset; then Q=0x0F, R=0x0F with Rdy 10 edges after start.
- WIDTH=8 handshake: Run dropped 3 cycles after start → Rdy high exactly one cycle. Run held high → Rdy stays high until Run falls, then a back-to-back operation is accepted.
